o_store_unit: RTL

Output writeback engine for AURA. Accepts finished output-row words (MEM_BLOCK, 64 bits) from the attention datapath and buffers them in a small FIFO. Drains them as MEM_STORE transactions to the O region starting at O_BASE, retrying whenever memory returns transaction tag 0. When the final line is accepted it raises a sticky `done`, which the top level exports.

---
 rtl/sys_defs.sv | 34 +++
 rtl/o_store_fifo.sv | 59 +++++
 rtl/o_store_unit.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/sys_defs.sv
// Shared AURA memory-interface types and constants used by the output store unit.
package sys_defs;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned BLOCK_W = 64;
    localparam int unsigned TAG_W   = 4;
    localparam int unsigned CMD_W   = 2;

    typedef logic [ADDR_W-1:0]  ADDR;
    typedef logic [BLOCK_W-1:0] MEM_BLOCK;
    typedef logic [TAG_W-1:0]   MEM_TAG;

    typedef enum logic [CMD_W-1:0] {
        MEM_NONE  = 2'h0,
        MEM_LOAD  = 2'h1,
        MEM_STORE = 2'h2
    } MEM_COMMAND;

    localparam ADDR O_BASE = 32'h0002_0000;

    typedef enum logic [1:0] {
        O_IDLE = 2'h0,
        O_RUN  = 2'h1,
        O_DONE = 2'h2
    } O_STORE_STATE;

    // One memory request as seen on the proc2mem bus.
    typedef struct packed {
        MEM_COMMAND command;
        ADDR        addr;
        MEM_BLOCK   data;
    } mem_req_t;

endpackage

// File: rtl/o_store_fifo.sv
// Synchronous FIFO with registered occupancy; no push-to-head bypass.
module o_store_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_q];

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (do_push) begin
            mem_d[wr_q] = push_data;
            wr_d        = wr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_d = rd_q + PTR_W'(1);
        end
        cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/o_store_unit.sv
// Output writeback engine: buffers O rows and stores them to BASE_ADDR with tag-0 retry.
// Optional accumulator of accepted store data enabled by O_STORE_CHECKSUM_EN.
module o_store_unit
    import sys_defs::*;
#(
    parameter int unsigned NUM_LINES  = 512,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter ADDR         BASE_ADDR  = O_BASE
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               o_valid,
    input  logic [BLOCK_W-1:0] o_data,
    output logic               o_ready,
    output logic [CMD_W-1:0]   proc2mem_command,
    output logic [ADDR_W-1:0]  proc2mem_addr,
    output logic [BLOCK_W-1:0] proc2mem_data,
    input  logic [TAG_W-1:0]   mem2proc_transaction_tag,
    output logic               done,
    output logic [BLOCK_W-1:0] checksum
);

    localparam int unsigned LINE_W = $clog2(NUM_LINES) + 1;

    O_STORE_STATE      state_q, state_d;
    logic [LINE_W-1:0] line_idx_q, line_idx_d;
    logic [LINE_W-1:0] push_cnt_q, push_cnt_d;
    logic              done_q, done_d;

    logic              fifo_full, fifo_empty;
    MEM_BLOCK          fifo_head;
    logic              push, issue, accept, arm;
    mem_req_t          req;

    // Ready and issue decode registered state only; the tag never reaches o_ready.
    assign o_ready = (state_q == O_RUN) && !fifo_full && (push_cnt_q < LINE_W'(NUM_LINES));
    assign push    = o_valid && o_ready;
    assign issue   = (state_q == O_RUN) && !fifo_empty;
    assign accept  = issue && (mem2proc_transaction_tag != '0);
    assign arm     = start && (state_q != O_RUN);

    o_store_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BLOCK_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (o_data),
        .pop       (accept),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        req = '{command: MEM_NONE, addr: '0, data: '0};
        if (issue) begin
            req.command = MEM_STORE;
            req.addr    = BASE_ADDR + (ADDR_W'(line_idx_q) << 3);
            req.data    = fifo_head;
        end
    end

    assign proc2mem_command = req.command;
    assign proc2mem_addr    = req.addr;
    assign proc2mem_data    = req.data;
    assign done             = done_q;

    always_comb begin
        state_d    = state_q;
        line_idx_d = line_idx_q;
        push_cnt_d = push_cnt_q;
        done_d     = done_q;
        case (state_q)
            O_IDLE, O_DONE: begin
                if (start) begin
                    state_d    = O_RUN;
                    line_idx_d = '0;
                    push_cnt_d = '0;
                    done_d     = 1'b0;
                end
            end
            O_RUN: begin
                if (push) begin
                    push_cnt_d = push_cnt_q + LINE_W'(1);
                end
                if (accept) begin
                    line_idx_d = line_idx_q + LINE_W'(1);
                    if (line_idx_q == LINE_W'(NUM_LINES - 1)) begin
                        state_d = O_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = O_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= O_IDLE;
            line_idx_q <= '0;
            push_cnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            line_idx_q <= line_idx_d;
            push_cnt_q <= push_cnt_d;
            done_q     <= done_d;
        end
    end

`ifdef O_STORE_CHECKSUM_EN
    MEM_BLOCK checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (arm) begin
            checksum_d = '0;
        end else if (accept) begin
            checksum_d = checksum_q ^ req.data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    logic unused_arm;
    assign unused_arm = arm;
    assign checksum   = '0;
`endif

endmodule
